// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - instruction issue, decode and status-register unit ahead of the ALU
// Three-phase sequencing: accept/decode in IDLE, execute, then complete.
module alu_issue_ctrl #(
    parameter int REG_AW = 4,
    parameter int IMM_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_instr_valid,
    input  logic [15:0]       i_instr,
    output logic              o_instr_ready,
    output logic [7:0]        o_alu_opcode,
    output logic [REG_AW-1:0] o_ra_addr,
    output logic [REG_AW-1:0] o_rb_addr,
    output logic [IMM_W-1:0]  o_imm,
    output logic              o_use_imm,
    output logic              o_alu_cin,
    input  logic [4:0]        i_alu_flags,
    output logic              o_reg_we,
    output logic [REG_AW-1:0] o_wb_addr,
    output logic [4:0]        o_psr,
    output logic              o_branch_taken,
    output logic [7:0]        o_branch_disp,
    output logic              o_done,
    output logic              o_illegal_op
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t r_state;
    state_t w_next;

    logic [3:0]        w_class;
    logic [3:0]        w_ext;
    logic [7:0]        w_opcode;
    logic [IMM_W-1:0]  w_imm;
    logic              w_use_imm;
    logic              w_we;
    logic              w_flag_wr;
    logic              w_is_branch;
    logic              w_is_illegal;
    logic              w_cond_true;

    logic [7:0]        r_opcode;
    logic [REG_AW-1:0] r_ra;
    logic [REG_AW-1:0] r_rb;
    logic [REG_AW-1:0] r_wb;
    logic [IMM_W-1:0]  r_imm;
    logic              r_use_imm;
    logic              r_we;
    logic              r_flag_wr;
    logic              r_is_branch;
    logic              r_is_illegal;
    logic [3:0]        r_cond;
    logic [7:0]        r_disp;
    logic [4:0]        r_psr;
    logic              r_branch_taken;
    logic              r_illegal;

    assign w_class = i_instr[15:12];
    assign w_ext   = i_instr[7:4];

    always_comb begin
        w_opcode     = 8'h00;
        w_imm        = '0;
        w_use_imm    = 1'b0;
        w_we         = 1'b0;
        w_flag_wr    = 1'b0;
        w_is_branch  = 1'b0;
        w_is_illegal = 1'b0;
        case (w_class)
            4'h0: begin
                w_opcode = {4'h0, w_ext};
                case (w_ext)
                    4'h0: ;
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                    4'h6, 4'h7, 4'h8, 4'h9: begin
                        w_we      = 1'b1;
                        w_flag_wr = 1'b1;
                    end
                    4'hB, 4'hF: w_flag_wr = 1'b1;
                    default:    w_is_illegal = 1'b1;
                endcase
            end
            4'h5, 4'h6, 4'h7: begin
                w_opcode  = {w_class, 4'h0};
                w_use_imm = 1'b1;
                w_we      = 1'b1;
                w_flag_wr = 1'b1;
                // ADDUI zero-extends; ADDI and ADDCI sign-extend
                if (w_class == 4'h6)
                    w_imm = IMM_W'(i_instr[7:0]);
                else
                    w_imm = IMM_W'($signed(i_instr[7:0]));
            end
            4'h8: begin
                case (w_ext)
                    4'h0: begin
                        w_opcode  = 8'h80;
                        w_use_imm = 1'b1;
                        w_imm     = IMM_W'(i_instr[3:0]);
                        w_we      = 1'b1;
                        w_flag_wr = 1'b1;
                    end
                    4'h4: begin
                        w_opcode  = 8'h84;
                        w_we      = 1'b1;
                        w_flag_wr = 1'b1;
                    end
                    default: w_is_illegal = 1'b1;
                endcase
            end
            4'hC:    w_is_branch  = 1'b1;
            default: w_is_illegal = 1'b1;
        endcase
    end

    // Condition is judged against psr before this instruction could update it
    always_comb begin
        w_cond_true = 1'b0;
        case (r_cond)
            4'h0: w_cond_true = r_psr[4];
            4'h1: w_cond_true = ~r_psr[4];
            4'h2: w_cond_true = r_psr[3];
            4'h3: w_cond_true = ~r_psr[3];
            4'h4: w_cond_true = r_psr[0];
            4'h5: w_cond_true = ~r_psr[0];
            4'h6: w_cond_true = r_psr[1];
            4'h7: w_cond_true = ~r_psr[1];
            4'hF: w_cond_true = 1'b1;
            default: w_cond_true = 1'b0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_instr_valid) w_next = S_EXEC;
            S_EXEC:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= S_IDLE;
            r_opcode       <= 8'h00;
            r_ra           <= '0;
            r_rb           <= '0;
            r_wb           <= '0;
            r_imm          <= '0;
            r_use_imm      <= 1'b0;
            r_we           <= 1'b0;
            r_flag_wr      <= 1'b0;
            r_is_branch    <= 1'b0;
            r_is_illegal   <= 1'b0;
            r_cond         <= 4'h0;
            r_disp         <= 8'h00;
            r_psr          <= 5'h00;
            r_branch_taken <= 1'b0;
            r_illegal      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && i_instr_valid) begin
                r_opcode     <= w_opcode;
                r_ra         <= REG_AW'(i_instr[11:8]);
                r_rb         <= REG_AW'(i_instr[3:0]);
                r_wb         <= REG_AW'(i_instr[11:8]);
                r_imm        <= w_imm;
                r_use_imm    <= w_use_imm;
                r_we         <= w_we;
                r_flag_wr    <= w_flag_wr;
                r_is_branch  <= w_is_branch;
                r_is_illegal <= w_is_illegal;
                r_cond       <= i_instr[11:8];
                r_disp       <= i_instr[7:0];
            end
            if (r_state == S_EXEC && r_flag_wr)
                r_psr <= i_alu_flags;
            r_branch_taken <= (r_state == S_EXEC) && r_is_branch && w_cond_true;
            r_illegal      <= (r_state == S_EXEC) && r_is_illegal;
        end
    end

    assign o_instr_ready  = (r_state == S_IDLE);
    assign o_alu_opcode   = r_opcode;
    assign o_ra_addr      = r_ra;
    assign o_rb_addr      = r_rb;
    assign o_imm          = r_imm;
    assign o_use_imm      = r_use_imm;
    assign o_alu_cin      = r_psr[3];
    assign o_reg_we       = (r_state == S_EXEC) && r_we;
    assign o_wb_addr      = r_wb;
    assign o_psr          = r_psr;
    assign o_branch_taken = r_branch_taken;
    assign o_branch_disp  = r_disp;
    assign o_done         = (r_state == S_DONE);
    assign o_illegal_op   = r_illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst;
    logic        i_instr_valid;
    logic [15:0] i_instr;
    logic [4:0]  i_alu_flags;
    logic        o_instr_ready;
    logic [7:0]  o_alu_opcode;
    logic [3:0]  o_ra_addr;
    logic [3:0]  o_rb_addr;
    logic [15:0] o_imm;
    logic        o_use_imm;
    logic        o_alu_cin;
    logic        o_reg_we;
    logic [3:0]  o_wb_addr;
    logic [4:0]  o_psr;
    logic        o_branch_taken;
    logic [7:0]  o_branch_disp;
    logic        o_done;
    logic        o_illegal_op;

    alu_issue_ctrl #(.REG_AW(4), .IMM_W(16)) dut (
        .i_clk(clk), .i_reset(rst), .i_instr_valid(i_instr_valid), .i_instr(i_instr),
        .o_instr_ready(o_instr_ready), .o_alu_opcode(o_alu_opcode), .o_ra_addr(o_ra_addr),
        .o_rb_addr(o_rb_addr), .o_imm(o_imm), .o_use_imm(o_use_imm), .o_alu_cin(o_alu_cin),
        .i_alu_flags(i_alu_flags), .o_reg_we(o_reg_we), .o_wb_addr(o_wb_addr), .o_psr(o_psr),
        .o_branch_taken(o_branch_taken), .o_branch_disp(o_branch_disp), .o_done(o_done),
        .o_illegal_op(o_illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [7:0]  op;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [3:0]  wb;
        logic [15:0] imm;
        logic        uimm;
        logic        we;
        logic        fw;
        logic        br;
        logic        ill;
        logic [3:0]  cond;
        logic [7:0]  disp;
    } dec_t;

    function automatic dec_t model_decode(input logic [15:0] w);
        dec_t d;
        logic [3:0] cls;
        logic [3:0] ext;
        cls = w[15:12];
        ext = w[7:4];
        d = '0;
        d.ra = w[11:8]; d.rb = w[3:0]; d.wb = w[11:8];
        d.cond = w[11:8]; d.disp = w[7:0];
        if (cls == 4'h0) begin
            d.op  = {4'h0, ext};
            d.ill = ext inside {4'hA, 4'hC, 4'hD, 4'hE};
            d.we  = ext inside {[4'h1:4'h9]};
            d.fw  = d.we || ext == 4'hB || ext == 4'hF;
        end else if (cls inside {4'h5, 4'h6, 4'h7}) begin
            d.op = {cls, 4'h0}; d.uimm = 1; d.we = 1; d.fw = 1;
            d.imm = (cls == 4'h6) ? {8'h00, w[7:0]} : {{8{w[7]}}, w[7:0]};
        end else if (cls == 4'h8 && ext == 4'h0) begin
            d.op = 8'h80; d.uimm = 1; d.imm = {12'h000, w[3:0]}; d.we = 1; d.fw = 1;
        end else if (cls == 4'h8 && ext == 4'h4) begin
            d.op = 8'h84; d.we = 1; d.fw = 1;
        end else if (cls == 4'hC) begin
            d.br = 1;
        end else begin
            d.ill = 1;
        end
        return d;
    endfunction

    function automatic logic model_taken(input logic [3:0] c, input logic [4:0] p);
        logic z, cy, n, l;
        {z, cy, n, l} = {p[4], p[3], p[1], p[0]};
        case (c)
            4'd0: return z;   4'd1: return !z;
            4'd2: return cy;  4'd3: return !cy;
            4'd4: return l;   4'd5: return !l;
            4'd6: return n;   4'd7: return !n;
            4'd15: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Model: cycles since acceptance (0 = waiting for an instruction)
    int         m_phase;
    dec_t       m_dec;
    logic [4:0] m_psr;
    logic       m_bt;
    logic       m_ill;
    logic       m_acc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_dec = '0; m_psr = 5'h00; m_bt = 0; m_ill = 0; m_acc = 0;
        end else begin
            m_acc = 0;
            if (m_phase == 0) begin
                if (i_instr_valid) begin
                    m_dec = model_decode(i_instr); m_phase = 1; m_acc = 1;
                end
            end else if (m_phase == 1) begin
                m_bt  = m_dec.br && model_taken(m_dec.cond, m_psr);
                m_ill = m_dec.ill;
                if (m_dec.fw) m_psr = i_alu_flags;
                m_phase = 2;
            end else begin
                m_bt = 0; m_ill = 0; m_phase = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("ready",   o_instr_ready,  m_phase == 0);
        chk("reg_we",  o_reg_we,       m_phase == 1 && m_dec.we);
        chk("done",    o_done,         m_phase == 2);
        chk("btaken",  o_branch_taken, m_bt);
        chk("illegal", o_illegal_op,   m_ill);
        chk("psr",     o_psr,          m_psr);
        chk("cin",     o_alu_cin,      m_psr[3]);
        if (m_phase == 1) begin
            chk("opcode",  o_alu_opcode, m_dec.op);
            chk("ra",      o_ra_addr,    m_dec.ra);
            chk("rb",      o_rb_addr,    m_dec.rb);
            chk("wb",      o_wb_addr,    m_dec.wb);
            chk("imm",     o_imm,        m_dec.imm);
            chk("use_imm", o_use_imm,    m_dec.uimm);
        end
        if (m_phase == 2 && m_dec.br)
            chk("disp", o_branch_disp, m_dec.disp);
    end

    // Leaves the bench at #1 after the negedge of the EXEC cycle
    task automatic issue(input logic [15:0] w, input logic [4:0] f);
        int k;
        k = 0;
        while (m_phase != 0 && k < 10) begin
            @(negedge clk); #1; k++;
        end
        chk("idle_wait", k < 10, 1);
        i_instr = w; i_alu_flags = f; i_instr_valid = 1;
        @(negedge clk); #1;
        i_instr_valid = 0;
    endtask

    task automatic next_cycle();
        @(negedge clk); #1;
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 7))
            0: r[15:12] = 4'h0;
            1: r[15:12] = 4'h5;
            2: r[15:12] = 4'h6;
            3: r[15:12] = 4'h7;
            4: begin
                r[15:12] = 4'h8;
                if ($urandom_range(0, 2) == 0) r[7:4] = 4'h0;
                else if ($urandom_range(0, 1) == 0) r[7:4] = 4'h4;
            end
            5, 6: r[15:12] = 4'hC;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        dec_t d;
        logic holding;
        rst = 1; i_instr_valid = 0; i_instr = 16'h0000; i_alu_flags = 5'h00;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_psr", o_psr, 5'h00);
        chk("rst_done", o_done, 0);
        chk("rst_we", o_reg_we, 0);
        chk("rst_ready", o_instr_ready, 1);
        rst = 0;

        d = model_decode(16'h51FE);
        chk("pin_addi_imm", d.imm, 16'hFFFE);
        d = model_decode(16'h61FE);
        chk("pin_addui_imm", d.imm, 16'h00FE);
        chk("pin_lt_taken", model_taken(4'h6, 5'b00011), 1);
        chk("pin_ge_taken", model_taken(4'h7, 5'b00011), 0);

        issue(16'h0251, 5'b01000);
        chk("add_op", o_alu_opcode, 8'h05);
        chk("add_ra", o_ra_addr, 4'd2);
        chk("add_rb", o_rb_addr, 4'd1);
        chk("add_we", o_reg_we, 1);
        chk("add_wb", o_wb_addr, 4'd2);
        chk("add_done_exec", o_done, 0);
        next_cycle();
        chk("add_done", o_done, 1);
        chk("add_psr", o_psr, 5'h08);

        issue(16'h0251, 5'b10000);
        rst = 1;
        #1;
        chk("rstx_we", o_reg_we, 0);
        chk("rstx_psr", o_psr, 5'h00);
        next_cycle();
        rst = 0;
        next_cycle();
        chk("rstx_nodone", o_done, 0);
        issue(16'h0251, 5'b01000);
        next_cycle();
        chk("rstx_readd_psr", o_psr, 5'h08);

        issue(16'h03B4, 5'b00011);
        chk("cmp_we", o_reg_we, 0);
        next_cycle();
        chk("cmp_psr", o_psr, 5'h03);
        issue(16'hC6F0, 5'b11111);
        next_cycle();
        chk("lt_taken", o_branch_taken, 1);
        chk("lt_disp", o_branch_disp, 8'hF0);
        chk("lt_psr", o_psr, 5'h03);
        issue(16'hC7F0, 5'b00000);
        next_cycle();
        chk("ge_taken", o_branch_taken, 0);

        issue(16'h51FE, 5'b01000);
        chk("addi_uimm", o_use_imm, 1);
        chk("addi_imm", o_imm, 16'hFFFE);
        chk("addi_op", o_alu_opcode, 8'h50);
        issue(16'h61FE, 5'b01000);
        chk("addui_imm", o_imm, 16'h00FE);
        issue(16'h7301, 5'b00000);
        chk("addci_cin", o_alu_cin, 1);
        issue(16'h8203, 5'b00100);
        chk("lshi_op", o_alu_opcode, 8'h80);
        chk("lshi_imm", o_imm, 16'h0003);

        issue(16'hF000, 5'b11111);
        chk("illf_we", o_reg_we, 0);
        next_cycle();
        chk("illf_pulse", o_illegal_op, 1);
        chk("illf_psr", o_psr, 5'h04);
        issue(16'h00A0, 5'b11111);
        chk("illa_we", o_reg_we, 0);
        next_cycle();
        chk("illa_pulse", o_illegal_op, 1);
        next_cycle();
        chk("illa_clear", o_illegal_op, 0);
        chk("illa_psr", o_psr, 5'h04);
        issue(16'h0000, 5'b11111);
        next_cycle();
        chk("nop_done", o_done, 1);
        chk("nop_ill", o_illegal_op, 0);
        chk("nop_psr", o_psr, 5'h04);

        holding = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk); #1;
            if (m_acc) holding = 0;
            i_alu_flags = 5'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                rst = 1; #2; rst = 0;
                holding = 0;
            end
            if (!holding) begin
                i_instr = rand_instr();
                if ($urandom_range(0, 3) != 0) begin
                    i_instr_valid = 1; holding = 1;
                end else begin
                    i_instr_valid = 0;
                end
            end
        end
        i_instr_valid = 0;
        repeat (4) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Instruction issue and flag-register unit that sits in front of the ALU.
- Accepts one 16-bit instruction word per valid/ready handshake and decodes it into the ALU opcode, register-file read/write addresses and immediate.
- Latches the ALU's ZCFNL flags into a processor status register (psr), feeds psr carry back as the ALU carry-in, and evaluates conditional branches against psr.
- Sequenced by a 3-state FSM; one instruction completes every 3 cycles.

Parameters:
- REG_AW, 4, register-file address width.
- IMM_W, 16, width of the immediate driven toward the ALU B operand mux.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr_valid  in  1  an instruction word is offered.
- instr  in  16  [15:12] class, [11:8] Rdest/cond, [7:4] ext/imm-hi, [3:0] Rsrc/imm-lo.
- instr_ready  out  1  high only in IDLE.
- alu_opcode  out  8  opcode to ALU.
- ra_addr  out  REG_AW  A-operand read address (Rdest).
- rb_addr  out  REG_AW  B-operand read address (Rsrc).
- imm  out  IMM_W  extended immediate.
- use_imm  out  1  selects imm instead of register B.
- alu_cin  out  1  equals psr[3].
- alu_flags  in  5  ZCFNL from ALU, valid combinationally during EXEC.
- reg_we  out  1  register-file write enable.
- wb_addr  out  REG_AW  write address (Rdest).
- psr  out  5  status register, ZCFNL; bit4 Z, bit3 C, bit2 F, bit1 N, bit0 L.
- branch_taken  out  1  valid in DONE only.
- branch_disp  out  8  instr[7:0], valid with branch_taken.
- done  out  1  one-cycle completion pulse.
- illegal_op  out  1  one-cycle pulse in DONE for an undefined encoding.

Behaviour:
- Reset is asynchronous and drives all outputs and psr to 0 and the FSM to IDLE, from any state. An instruction in flight is discarded with no write and no done.
- IDLE:
  - instr_ready=1.
  - When instr_valid is high at a clock edge: capture instr, register all decode outputs, go to EXEC.
- EXEC (1 cycle):
  - alu_opcode, ra_addr, rb_addr, imm, use_imm and wb_addr are stable.
  - reg_we is high per decode, so the register file writes at the EXEC→DONE edge.
  - At that same edge, psr<=alu_flags if flag_wr.
  - branch_taken and illegal_op are registered at that edge.
- DONE (1 cycle): done=1, then go to IDLE. instr_ready=0 in EXEC and DONE.
- Decode for class 0000:
  - alu_opcode={0000, ext}, use_imm=0.
  - ext 0000 is NOP: no reg_we, no flag_wr.
  - ext 1,2,3,4,5,6,7,8,9: reg_we=1, flag_wr=1.
  - ext B (CMP) and F (CMPU): reg_we=0, flag_wr=1.
  - ext A, C, D, E: illegal.
- Decode for classes 0101 (ADDI), 0110 (ADDUI) and 0111 (ADDCI):
  - alu_opcode={class, 0000}, use_imm=1, reg_we=1, flag_wr=1.
  - imm is instr[7:0], sign-extended for 0101 and 0111, zero-extended for 0110.
- Decode for class 1000 (shifts):
  - ext 0000 (LSHI): alu_opcode=8'h80, use_imm=1, imm=zero-extended instr[3:0].
  - ext 0100 (LSH): alu_opcode=8'h84, use_imm=0.
  - Both: reg_we=1, flag_wr=1. Any other ext is illegal.
- Decode for class 1100 (Bcond):
  - No reg_we, no flag_wr, alu_opcode=0.
  - cond=instr[11:8], evaluated against psr as it stands during EXEC (pre-update):
    - 0 EQ Z=1, 1 NE Z=0, 2 CS C=1, 3 CC C=0.
    - 4 LO L=1, 5 HS L=0, 6 LT N=1, 7 GE N=0.
    - F always taken. 8–E never taken.
  - branch_disp=instr[7:0].
- Any other class is illegal: illegal_op=1 in DONE, no reg_we, psr unchanged.
- branch_taken and illegal_op return to 0 when leaving DONE.
- instr_valid while not in IDLE is ignored; the producer must hold it.

Test Plan:
- Reset mid-EXEC of ADD (instr=0x0251): reset asserted in EXEC → reg_we drops immediately, psr=0, no done, next instruction accepted normally.
- ADD R2,R1 (0x0251) with alu_flags=5'b01000 → EXEC: alu_opcode=0x05, ra=2, rb=1, reg_we=1, wb_addr=2; then psr=0x08, done pulse 2 cycles after accept.
- CMP (0x03B4) with alu_flags=5'b00011 → reg_we=0 throughout, psr=0x03. Following Bcond LT (0xC6F0) → branch_taken=1, branch_disp=0xF0. Bcond GE (0xC7F0) → taken=0.
- ADDI R1,#-2 (0x51FE) → use_imm=1, imm=0xFFFE, alu_opcode=0x50. ADDUI (0x61FE) → imm=0x00FE.
- With psr[3]=1, ADDCI (0x7301) → alu_cin=1 during EXEC. LSHI (0x8203) → alu_opcode=0x80, imm=0x0003.
- Illegal class 0xF000 and class 0000 ext A (0x00A0) → illegal_op pulse, no reg_we, psr unchanged. NOP (0x0000) → done only, no illegal_op.
